// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front end: function codes, sequencer states
// and the default datapath MSB index.
package alu_pkg;

    localparam int NUM_BITS_DEFAULT = 7;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    typedef enum logic [2:0] {
        S_A      = 3'd0,
        S_B      = 3'd1,
        S_F      = 3'd2,
        S_EXEC   = 3'd3,
        S_RESULT = 3'd4
    } state_t;

endpackage

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and F words from one input bus, holds them stable for the ALU,
// and returns the captured ALU result on a valid/ready result port.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEFAULT,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BITS:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [NUM_BITS:0]   alu_a,
    output logic [NUM_BITS:0]   alu_b,
    output logic [1:0]          alu_f,
    input  logic [NUM_BITS:0]   alu_out,
    input  logic                alu_flag_o,
    output logic [NUM_BITS:0]   res_data,
    output logic                res_ovf,
    output logic [1:0]          res_f,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [CNT_W-1:0]    op_count,
    output logic                busy,
    output state_t              dbg_state
);

    // Handshake rule: a word moves on a rising edge where valid && ready are
    // both high; ready never depends combinationally on valid.
    state_t state;
    state_t state_nxt;
    logic   in_xfer;
    logic   res_xfer;

    assign in_xfer   = in_valid && in_ready;
    assign res_xfer  = res_valid && res_ready;
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            S_A: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_B;
            end
            S_B: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_F;
            end
            S_F: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                busy      = 1'b1;
                state_nxt = S_RESULT;
            end
            S_RESULT: begin
                busy = 1'b1;
                if (res_xfer) state_nxt = S_A;
            end
            default: state_nxt = S_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_A;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_f     <= '0;
            res_data  <= '0;
            res_ovf   <= 1'b0;
            res_f     <= '0;
            res_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_A: if (in_xfer) alu_a <= in_data;
                S_B: if (in_xfer) alu_b <= in_data;
                S_F: if (in_xfer) alu_f <= in_data[1:0];
                S_EXEC: begin
                    res_data  <= alu_out;
                    res_f     <= alu_f;
                    // Overflow only carries meaning for ADD; other flags are dropped.
                    res_ovf   <= (alu_f == ALU_ADD) && alu_flag_o;
                    res_valid <= 1'b1;
                end
                S_RESULT: begin
                    if (res_xfer) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer with a 4-function ALU alongside it and a
// queue-based scoreboard fed from an arithmetic reference model.
module tb_alu_operand_sequencer;
    import alu_pkg::*;

    localparam int NB = 7;
    localparam int W  = NB + 1;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [1:0]    alu_f;
    logic [W-1:0]  alu_out;
    logic          alu_flag_o;
    logic [W-1:0]  res_data;
    logic          res_ovf;
    logic [1:0]    res_f;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] op_count;
    logic          busy;
    state_t        dbg_state;

    alu_operand_sequencer #(.NUM_BITS(NB), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_out(alu_out), .alu_flag_o(alu_flag_o),
        .res_data(res_data), .res_ovf(res_ovf), .res_f(res_f),
        .res_valid(res_valid), .res_ready(res_ready),
        .op_count(op_count), .busy(busy), .dbg_state(dbg_state)
    );

    // ALU: ADD flags signed overflow, SUB flags carry-out, logic ops flag parity.
    logic [W:0] alu_sum;
    always_comb begin
        alu_sum    = '0;
        alu_out    = '0;
        alu_flag_o = 1'b0;
        case (alu_f)
            ALU_AND: begin alu_out = alu_a & alu_b; alu_flag_o = ^alu_out; end
            ALU_OR:  begin alu_out = alu_a | alu_b; alu_flag_o = ^alu_out; end
            ALU_ADD: begin
                alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out    = alu_sum[W-1:0];
                alu_flag_o = (alu_a[W-1] == alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
            end
            default: begin
                alu_sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1;
                alu_out    = alu_sum[W-1:0];
                alu_flag_o = alu_sum[W];
            end
        endcase
    end

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int passed = 0;
    int exp_cnt = 0;
    bit rdy_rand = 1'b0;
    bit rdy_force = 1'b1;
    logic [W+2:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: plain integer arithmetic, packed as {f, ovf, data}.
    function automatic logic [W+2:0] ref_model(input int a, input int b, input int f);
        int m;
        int r;
        int sa;
        int sb;
        logic o;
        logic [1:0] fv;
        logic [W-1:0] rv;
        m  = 1 << W;
        o  = 1'b0;
        r  = 0;
        fv = f[1:0];
        case (f)
            0: r = a & b;
            1: r = a | b;
            2: begin
                r  = (a + b) % m;
                sa = (a >= m / 2) ? a - m : a;
                sb = (b >= m / 2) ? b - m : b;
                o  = ((sa + sb) > (m / 2 - 1)) || ((sa + sb) < -(m / 2));
            end
            default: r = (a - b + m) % m;
        endcase
        rv = r[W-1:0];
        return {fv, o, rv};
    endfunction

    // result consumer
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            res_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // monitor: handshake seen at negedge completes on the following posedge
    initial begin
        logic [W+2:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_cnt = 0;
            end else if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", 32'(res_data), 32'(e[W-1:0]));
                    check("res_ovf", 32'(res_ovf), 32'(e[W]));
                    check("res_f", 32'(res_f), 32'(e[W+2:W+1]));
                end
                check("op_count_before", 32'(op_count), 32'(exp_cnt % (1 << CW)));
                exp_cnt++;
            end
        end
    end

    // driver tasks
    task automatic send_word(input logic [W-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_data  = W'($urandom);
                return;
            end
        end
        in_valid = 1'b0;
        check("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_gap(input int max_cycles);
        int n;
        n = $urandom_range(0, max_cycles);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_op(input int a, input int b, input int fw, input bit check_lat, input int gap);
        send_word(W'(a));
        idle_gap(gap);
        send_word(W'(b));
        idle_gap(gap);
        exp_q.push_back(ref_model(a, b, fw & 3));
        send_word(W'(fw));
        if (check_lat) begin
            @(negedge clk);
            check("lat_exec_valid", 32'(res_valid), 32'd0);
            check("lat_exec_busy", 32'(busy), 32'd1);
            check("lat_exec_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            check("lat_result_valid", 32'(res_valid), 32'd1);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check({tag, "_alu_f"}, 32'(alu_f), 32'd0);
        check({tag, "_res_data"}, 32'(res_data), 32'd0);
        check({tag, "_res_ovf"}, 32'(res_ovf), 32'd0);
        check({tag, "_res_f"}, 32'(res_f), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_op_count"}, 32'(op_count), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_gap(3);

        // directed operations, consumer always ready
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        do_op(8'h05, 8'h03, 8'h02, 1'b1, 0);
        wait_drain();
        check("op_count_first", 32'(op_count), 32'd1);
        do_op(8'h7F, 8'h01, 8'h02, 1'b1, 2);
        do_op(8'h80, 8'h80, 8'h03, 1'b0, 1);
        do_op(8'h0C, 8'h0A, 8'h00, 1'b0, 0);
        do_op(8'h0C, 8'h0A, 8'hFD, 1'b0, 3);
        wait_drain();
        check("op_count_directed", 32'(op_count), 32'd5);

        // backpressure with in_valid pulses that must not be captured
        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        do_op(8'h21, 8'h42, 8'h02, 1'b0, 0);
        for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            @(negedge clk);
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_res_data", 32'(res_data), 32'h63);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_alu_a", 32'(alu_a), 32'h21);
            check("bp_alu_b", 32'(alu_b), 32'h42);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        rdy_force = 1'b1;
        @(posedge clk);
        #1;
        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(res_valid), 32'd0);
        check("bp_release_state", 32'(dbg_state), 32'(S_A));
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("op_count_bp", 32'(op_count), 32'd6);
        rdy_force = 1'b1;

        // reset while waiting in S_B
        rdy_rand = 1'b1;
        send_word(8'h55);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_op(8'h05, 8'h03, 8'h02, 1'b0, 1);

        // randomized operations; 256 results since the reset wrap the counter
        for (int n = 0; n < 255; n++) begin
            do_op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 2);
        end
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
        check("op_count_wrap", 32'(op_count), 32'd0);
        check("final_idle_in_ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, got %0d checks", checks);
        $fatal(1, "timeout");
    end

endmodule
